// File: rtl/simplez_pkg.sv
// Shared types and defaults for the Simplez program loader.
package simplez_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_HI,
        S_LO,
        S_CHK,
        S_RUN
    } state_t;

    localparam logic [7:0] SYNC_DEF = 8'h4C;
    localparam int         AW_DEF   = 9;
    localparam int         DW_DEF   = 12;

endpackage

// File: rtl/simplez_loader_timeout.sv
// Inter-byte idle watchdog: loadable down-counter that flags expiry at zero.
module loader_timeout #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clear,
    input  logic         ena,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= load_val;
        end else if (ena && cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expired = ena && (cnt == '0);

endmodule

// File: rtl/simplez_loader.sv
// Serial frame loader: fills program RAM from uart_rx bytes and
// holds the CPU in reset until the frame checksum verifies.
module simplez_loader
    import simplez_pkg::*;
#(
    parameter int          AW      = AW_DEF,
    parameter int          DW      = DW_DEF,
    parameter logic [7:0]  SYNC    = SYNC_DEF,
    parameter logic [23:0] TIMEOUT = 24'd1_200_000
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          rcv,
    input  logic [7:0]    data,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_we,
    output logic          cpu_rstn,
    output logic          busy,
    output logic          done,
    output logic          err
);

    state_t        st;
    logic [7:0]    cnt;
    logic [7:0]    sum;
    logic [DW-9:0] hi;
    logic          active;
    logic          to_exp;

    assign active = (st == S_LEN) || (st == S_HI) ||
                    (st == S_LO)  || (st == S_CHK);

    loader_timeout #(.W(24)) u_timeout (
        .clk      (clk),
        .rstn     (rstn),
        .clear    (rcv || !active),
        .ena      (active),
        .load_val (TIMEOUT),
        .expired  (to_exp)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st       <= S_IDLE;
            cnt      <= '0;
            sum      <= '0;
            hi       <= '0;
            ram_addr <= '0;
            ram_din  <= '0;
            ram_we   <= 1'b0;
            cpu_rstn <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            ram_we <= 1'b0;
            if (ram_we) begin
                ram_addr <= ram_addr + AW'(1);
            end
            // a byte arriving on the expiry cycle takes priority
            if (active && !rcv && to_exp) begin
                err  <= 1'b1;
                busy <= 1'b0;
                st   <= S_IDLE;
            end else if (rcv) begin
                unique case (st)
                    S_IDLE, S_RUN: begin
                        if (data == SYNC) begin
                            err      <= 1'b0;
                            busy     <= 1'b1;
                            done     <= 1'b0;
                            cpu_rstn <= 1'b0;
                            st       <= S_LEN;
                        end
                    end
                    S_LEN: begin
                        cnt      <= data;
                        sum      <= data;
                        ram_addr <= '0;
                        st       <= (data == 8'd0) ? S_CHK : S_HI;
                    end
                    S_HI: begin
                        hi  <= data[DW-9:0];
                        sum <= sum + data;
                        st  <= S_LO;
                    end
                    S_LO: begin
                        sum     <= sum + data;
                        ram_din <= {hi, data};
                        ram_we  <= 1'b1;
                        cnt     <= cnt - 8'd1;
                        st      <= (cnt == 8'd1) ? S_CHK : S_HI;
                    end
                    S_CHK: begin
                        busy <= 1'b0;
                        if (data == sum) begin
                            cpu_rstn <= 1'b1;
                            done     <= 1'b1;
                            st       <= S_RUN;
                        end else begin
                            err <= 1'b1;
                            st  <= S_IDLE;
                        end
                    end
                    default: st <= S_IDLE;
                endcase
            end
        end
    end

endmodule
